psum_accumulator: RTL

//   Final partial-sum accumulation stage directly upstream of the adder packetizer.
//   - Receives 47-bit psum packets from the PE rows over the NoC.
//   - Adds one partial sum from each of NUM_SRC sources into a single output value.
//   - Saturates the result to DWIDTH bits.
//   - Hands the result to the packetizer over a valid/ready channel.
//   - Duplicate sources are stalled, misrouted packets are dropped, and everything is counted.

---
 rtl/psum_accumulator_if.sv | 31 +++
 rtl/psum_accumulator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_if.sv
// Stream bundle between the NoC psum input and the packetizer output of psum_accumulator.
// The master side is the environment (producer and packetizer); the slave side is the accumulator.
interface psum_accumulator_if #(
   parameter int unsigned PWIDTH = 47,
   parameter int unsigned DWIDTH = 8
);
   logic [PWIDTH-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DWIDTH-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/psum_accumulator.sv
// Sums one partial sum from each of NUM_SRC sources, saturates to DWIDTH bits and
// hands the result to the packetizer; duplicates stall, misrouted packets are dropped.
module psum_accumulator #(
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned PWIDTH     = 47,
   parameter int unsigned NUM_SRC    = 3,
   parameter logic [2:0]  ADDER_ADDR = 3'b100
) (
   input  logic                    clk,
   input  logic                    rst,
   psum_accumulator_if.slave       bus,
   output logic                    sat_flag,
   output logic [7:0]              err_count,
   output logic [15:0]             out_count
);

   localparam int unsigned AWIDTH = DWIDTH + 3;
   localparam logic [3:0]  NSRC   = 4'(NUM_SRC);

   typedef enum logic {
      ACCUM,
      OUTPUT
   } state_t;

   state_t              state, state_n;
   logic [AWIDTH-1:0]   acc, acc_n;
   logic [NUM_SRC-1:0]  mask, mask_n;
   logic [DWIDTH-1:0]   out_data_q, out_data_n;
   logic                out_valid_q, out_valid_n;
   logic                sat_n;
   logic [7:0]          err_n;
   logic [15:0]         cnt_n;

   logic [2:0]          dest;
   logic [2:0]          src;
   logic [DWIDTH-1:0]   psum;
   logic                in_range;
   logic                misroute;
   logic [NUM_SRC-1:0]  src_bit;
   logic                dup;
   logic                ready;
   logic                accept;
   logic [AWIDTH-1:0]   acc_sum;
   logic [NUM_SRC-1:0]  mask_sum;
   logic                over;
   logic                unused_bits;

   assign dest = bus.in_data[45:43];
   assign src  = bus.in_data[42:40];
   assign psum = bus.in_data[DWIDTH-1:0];

   // Type bit and the padding between src and psum carry nothing for this stage.
   assign unused_bits = ^{bus.in_data[PWIDTH-1], bus.in_data[PWIDTH-8:DWIDTH]};

   always_comb begin
      in_range = ({1'b0, src} < NSRC);
      misroute = (dest != ADDER_ADDR) || !in_range;
      src_bit  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         src_bit[i] = in_range && (src == 3'(i));
      end
      dup      = |(mask & src_bit);
      ready    = !rst && (state == ACCUM) && !(bus.in_valid && !misroute && dup);
      accept   = bus.in_valid && ready;
      acc_sum  = acc + {3'b000, psum};
      mask_sum = mask | src_bit;
      over     = |acc_sum[AWIDTH-1:DWIDTH];
   end

   assign bus.in_ready  = ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;

   always_comb begin
      state_n     = state;
      acc_n       = acc;
      mask_n      = mask;
      out_data_n  = out_data_q;
      out_valid_n = out_valid_q;
      sat_n       = sat_flag;
      err_n       = err_count;
      cnt_n       = out_count;
      case (state)
         ACCUM: begin
            if (accept) begin
               if (misroute) begin
                  err_n = (&err_count) ? err_count : err_count + 8'd1;
               end else begin
                  acc_n  = acc_sum;
                  mask_n = mask_sum;
                  if (&mask_sum) begin
                     out_valid_n = 1'b1;
                     out_data_n  = over ? '1 : acc_sum[DWIDTH-1:0];
                     sat_n       = over;
                     state_n     = OUTPUT;
                  end
               end
            end
         end
         OUTPUT: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_n = 1'b0;
               acc_n       = '0;
               mask_n      = '0;
               cnt_n       = out_count + 16'd1;
               state_n     = ACCUM;
            end
         end
         default: state_n = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         mask        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sat_flag    <= 1'b0;
         err_count   <= '0;
         out_count   <= '0;
      end else begin
         acc         <= acc_n;
         mask        <= mask_n;
         out_data_q  <= out_data_n;
         out_valid_q <= out_valid_n;
         sat_flag    <= sat_n;
         err_count   <= err_n;
         out_count   <= cnt_n;
      end
   end

endmodule
